// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants for the instruction loader and the core's control unit:
// op_sel codes, RV32I opcode/funct fields and the halt word.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8
  } op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_HALT   = 7'b1111111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] HALT_WORD = {25'd0, OPC_HALT};

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_WRITE,
    ST_HALT_WR,
    ST_DONE
  } state_e;

  function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_RTYPE};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational encoder: op_sel plus register/immediate fields into one RV32I word,
// flagging op_sel codes outside the supported set.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_sel)
      OP_ADD:  word = r_word(F7_BASE, rs2, rs1, F3_ADD_SUB, rd);
      OP_SUB:  word = r_word(F7_SUB,  rs2, rs1, F3_ADD_SUB, rd);
      OP_AND:  word = r_word(F7_BASE, rs2, rs1, F3_AND, rd);
      OP_OR:   word = r_word(F7_BASE, rs2, rs1, F3_OR, rd);
      OP_SLT:  word = r_word(F7_BASE, rs2, rs1, F3_SLT, rd);
      OP_LW:   word = {imm, rs1, F3_LW, rd, OPC_LOAD};
      OP_ADDI: word = {imm, rs1, F3_ADDI, rd, OPC_OPIMM};
      OP_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      // imm holds offset bits [12:1]: imm[11]=o12, imm[10]=o11, imm[9:4]=o[10:5], imm[3:0]=o[4:1]
      OP_BEQ:  word = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded instructions into a 64-word instruction memory, one per two cycles,
// and terminates the program with a halt word on request or when memory is full.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  input  logic        finish,
  input  logic        restart,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        err,
  output logic [6:0]  count
);

  state_e      state, state_nx;
  logic [5:0]  addr_ptr;
  logic [6:0]  count_q;
  logic        err_q;
  logic        fin_pend;
  logic [31:0] word_q;
  logic [31:0] packed_word;
  logic        illegal;

  instr_field_packer u_packer (
    .op_sel  (op_sel),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .word    (packed_word),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_ACCEPT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    done       = 1'b0;
    imem_wdata = word_q;
    case (state)
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid && !illegal) state_nx = ST_WRITE;
        else if (finish)          state_nx = ST_HALT_WR;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        // A finish arriving during the write counts as pending for this decision
        if (addr_ptr == 6'd62 || fin_pend || finish) state_nx = ST_HALT_WR;
        else                                         state_nx = ST_ACCEPT;
      end
      ST_HALT_WR: begin
        imem_we    = 1'b1;
        imem_wdata = HALT_WORD;
        state_nx   = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (restart) state_nx = ST_ACCEPT;
      end
      default: state_nx = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_ptr <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      fin_pend <= 1'b0;
      word_q   <= '0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (in_valid) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              word_q   <= packed_word;
              fin_pend <= finish;
            end
          end
        end
        ST_WRITE: begin
          addr_ptr <= addr_ptr + 6'd1;
          count_q  <= count_q + 7'd1;
          fin_pend <= 1'b0;
        end
        ST_HALT_WR: count_q <= count_q + 7'd1;
        ST_DONE: begin
          if (restart) begin
            addr_ptr <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            fin_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = addr_ptr;
  assign err       = err_q;
  assign count     = count_q;

endmodule
